// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit-side arbiter: FSM encoding, parity types, defaults.
package uart_tx_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned BUSY_TMO_DEF = 4;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, else first set from 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    // Upper segment [ptr, NUM_REQ-1] first, then wrap to [0, ptr-1].
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_c && req[j] && (IDX_W'(j) >= ptr)) begin
        gnt_c[j] = 1'b1;
        idx_c    = IDX_W'(j);
        any_c    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_c && req[j]) begin
        gnt_c[j] = 1'b1;
        idx_c    = IDX_W'(j);
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, sequencing Data_Valid/Busy
// and holding the winner's byte and parity configuration for the whole frame.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_par_en,
  input  logic [NUM_REQ-1:0]         req_par_typ,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_p_data,
  output logic                       tx_data_valid,
  output logic                       tx_par_en,
  output logic                       tx_par_typ,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       frame_done,
  output logic                       tmo_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ready_d;
  logic [7:0]         p_data_d;
  logic               dv_d, par_en_d, par_typ_d, done_d, tmo_d;
  logic [IDX_W-1:0]   gnt_id_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [7:0]         win_data;
  logic               win_par_en, win_par_typ;
  logic [IDX_W-1:0]   ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  // One-hot select of the winner's byte and parity configuration.
  always_comb begin
    win_data    = '0;
    win_par_en  = 1'b0;
    win_par_typ = PAR_EVEN;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_data    = req_data[8*i +: 8];
        win_par_en  = req_par_en[i];
        win_par_typ = req_par_typ[i];
      end
    end
  end

  assign ptr_next = (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ready_d   = '0;
    dv_d      = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    p_data_d  = tx_p_data;
    par_en_d  = tx_par_en;
    par_typ_d = tx_par_typ;
    gnt_id_d  = gnt_id;
    case (state_q)
      ST_IDLE: begin
        if (arb_any && !tx_busy) begin
          ready_d   = arb_gnt;
          p_data_d  = win_data;
          par_en_d  = win_par_en;
          par_typ_d = win_par_typ;
          gnt_id_d  = arb_idx;
          dv_d      = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(BUSY_TMO)) begin
            tmo_d   = 1'b1;
            ptr_d   = ptr_next;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      req_ready     <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= PAR_EVEN;
      gnt_id        <= '0;
      frame_done    <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      req_ready     <= ready_d;
      tx_p_data     <= p_data_d;
      tx_data_valid <= dv_d;
      tx_par_en     <= par_en_d;
      tx_par_typ    <= par_typ_d;
      gnt_id        <= gnt_id_d;
      frame_done    <= done_d;
      tmo_err       <= tmo_d;
    end
  end

endmodule
